// File: rtl/array_init_arbiter.sv
// array_init_arbiter
//   Owns a DEPTH x WIDTH register array. On command it fills the array with
//   either a constant word or an indexed pattern, one entry per cycle. Once
//   filled, two requesters share the single access port under round-robin
//   arbitration. Reads return registered data tagged with the requester id.
module array_init_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 200,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_start,
  input  logic             init_mode,
  input  logic [WIDTH-1:0] init_value,
  output logic             init_busy,
  output logic             init_done,
  input  logic             req0_valid,
  input  logic             req0_we,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_wdata,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_we,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_rdata
);

  // One extra bit so the bound compare also works when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    UNINIT = 2'd0,
    INIT   = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Storage array: deliberately not reset, contents are defined only by a fill.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    fill_idx;
  logic             fill_mode_q;
  logic [WIDTH-1:0] fill_value_q;
  logic             done_q;

  // Round-robin pointer: 1 means req1 was granted last, so req0 wins a tie.
  logic             last_gnt;

  logic             gnt0, gnt1, gnt;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             addr_ok;
  logic [WIDTH-1:0] fill_word;
  logic [WIDTH-1:0] rd_word;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic             vld_p1;
  logic             id_p1;
  logic [WIDTH-1:0] rdata_p1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= UNINIT;
    else     state_q <= state_d;
  end

  // Next state, busy flag and round-robin grants.
  always_comb begin
    state_d   = state_q;
    init_busy = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    unique case (state_q)
      UNINIT: begin
        if (init_start) state_d = INIT;
      end
      INIT: begin
        init_busy = 1'b1;
        if (fill_idx == LAST_IDX) state_d = READY;
      end
      READY: begin
        if (init_start) begin
          // A fill request takes the cycle; nothing is granted.
          state_d = INIT;
        end else if (req0_valid && req1_valid) begin
          if (last_gnt) gnt0 = 1'b1;
          else          gnt1 = 1'b1;
        end else if (req0_valid) begin
          gnt0 = 1'b1;
        end else if (req1_valid) begin
          gnt1 = 1'b1;
        end
      end
      default: state_d = UNINIT;
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign gnt        = gnt0 | gnt1;

  // Payload of whichever requester holds the grant.
  assign sel_we    = gnt1 ? req1_we    : req0_we;
  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;
  assign addr_ok   = ({1'b0, sel_addr} < DEPTH_X);

  // Fill word: constant, or base shifted into the upper half OR'd with the index.
  assign fill_word = fill_mode_q ? ((fill_value_q << 16) | WIDTH'(fill_idx))
                                 : fill_value_q;

  // Single write port shared by the fill sequencer and granted writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sel_addr;
    mem_wdata = sel_wdata;
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = fill_idx;
      mem_wdata = fill_word;
    end else if (gnt && sel_we && addr_ok) begin
      mem_we = 1'b1;
    end
  end

  // Array write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Out-of-range reads return zero instead of indexing past the array.
  assign rd_word = addr_ok ? mem[sel_addr] : '0;

  // Capture fill mode and base on the accepted start cycle; held for the whole fill.
  always_ff @(posedge clk) begin
    if (state_q != INIT && init_start) begin
      fill_mode_q  <= init_mode;
      fill_value_q <= init_value;
    end
  end

  // Fill index, completion pulse and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_idx <= '0;
      done_q   <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      done_q <= (state_q == INIT) && (fill_idx == LAST_IDX);
      if (state_q == INIT && fill_idx != LAST_IDX) fill_idx <= fill_idx + AW'(1);
      else                                         fill_idx <= '0;
      if (gnt) last_gnt <= gnt1;
    end
  end

  assign init_done = done_q;

  // ---- stage p1: registered read response, one cycle after the grant ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      id_p1    <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= gnt && !sel_we;
      if (gnt && !sel_we) begin
        id_p1    <= gnt1;
        rdata_p1 <= rd_word;
      end
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_id    = id_p1;
  assign rsp_rdata = rdata_p1;

endmodule

// File: tb/tb_array_init_arbiter.sv
// Directed testbench for array_init_arbiter (WIDTH 32, DEPTH 200).
module tb_array_init_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_start, init_mode;
  logic [31:0] init_value;
  logic        init_busy, init_done;
  logic        req0_valid, req0_we, req0_ready;
  logic [7:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_we, req1_ready;
  logic [7:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  array_init_arbiter #(.WIDTH(32), .DEPTH(200)) dut (
    .clk(clk), .rst(rst),
    .init_start(init_start), .init_mode(init_mode), .init_value(init_value),
    .init_busy(init_busy), .init_done(init_done),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One single-requester transfer; returns observed grant and next-cycle response.
  task automatic issue(input int id, input logic we, input logic [7:0] addr,
                       input logic [31:0] wdata, output logic rdy,
                       output logic rv, output logic rid, output logic [31:0] rd);
    if (id == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
    #1;
    rdy = (id == 0) ? req0_ready : req1_ready;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rv  = rsp_valid;
    rid = rsp_id;
    rd  = rsp_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_start = 1'b0; init_mode = 1'b0; init_value = '0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    repeat (3) step();
    total_cnt++; if (init_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", init_busy); else pass_cnt++;
    total_cnt++; if (init_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", init_done); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL uninit_ready got=%b exp=00", {req0_ready, req1_ready}); else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  // Start a fill and measure the busy window and the done pulse.
  task automatic test_fill(input logic mode, input logic [31:0] value, input string nm);
    int busy_cnt, done_cnt, last_busy, done_at;
    busy_cnt = 0; done_cnt = 0; last_busy = -1; done_at = -1;
    init_start = 1'b1; init_mode = mode; init_value = value;
    step();
    init_start = 1'b0; init_mode = ~mode; init_value = ~value;
    for (int i = 0; i < 220; i++) begin
      if (init_busy === 1'b1) begin busy_cnt++; last_busy = i; end
      if (init_done === 1'b1) begin done_cnt++; done_at = i; end
      step();
    end
    total_cnt++; if (busy_cnt != 200) $display("FAIL %s_busy_cycles got=%0d exp=200", nm, busy_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL %s_done_pulses got=%0d exp=1", nm, done_cnt); else pass_cnt++;
    total_cnt++; if (done_at != last_busy + 1) $display("FAIL %s_done_timing got=%0d exp=%0d", nm, done_at, last_busy + 1); else pass_cnt++;
  endtask

  task automatic test_reads(input string nm, input int id, input logic [7:0] addr, input logic [31:0] exp);
    logic rdy, rv, rid;
    logic [31:0] rd;
    issue(id, 1'b0, addr, 32'h0, rdy, rv, rid, rd);
    total_cnt++; if (rdy !== 1'b1) $display("FAIL %s_ready got=%b exp=1", nm, rdy); else pass_cnt++;
    total_cnt++; if (rv !== 1'b1 || rid !== id[0]) $display("FAIL %s_rsp got valid=%b id=%b exp valid=1 id=%0d", nm, rv, rid, id); else pass_cnt++;
    total_cnt++; if (rd !== exp) $display("FAIL %s_rdata got=%h exp=%h", nm, rd, exp); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic exp_id;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'd0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'd1;
    for (int i = 0; i < 6; i++) begin
      exp_id = i[0];
      #1;
      total_cnt++; if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) $display("FAIL rr_grant%0d got=%b exp_id=%b", i, {req1_ready, req0_ready}, exp_id); else pass_cnt++;
      step();
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_rdata !== (exp_id ? 32'hff120001 : 32'hff120000))
        $display("FAIL rr_rsp%0d got valid=%b id=%b data=%h exp id=%b", i, rsp_valid, rsp_id, rsp_rdata, exp_id);
      else pass_cnt++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rr_idle_rsp got=%b exp=0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_write_then_read();
    logic rdy, rv, rid;
    logic [31:0] rd;
    issue(0, 1'b1, 8'd5, 32'h1, rdy, rv, rid, rd);
    total_cnt++; if (rdy !== 1'b1) $display("FAIL wr_ready got=%b exp=1", rdy); else pass_cnt++;
    total_cnt++; if (rv !== 1'b0) $display("FAIL wr_no_rsp got=%b exp=0", rv); else pass_cnt++;
    test_reads("raw_addr5", 1, 8'd5, 32'h1);
  endtask

  task automatic test_out_of_range();
    logic rdy, rv, rid;
    logic [31:0] rd;
    test_reads("oor_read", 0, 8'd200, 32'h0);
    issue(1, 1'b1, 8'd200, 32'hdeadbeef, rdy, rv, rid, rd);
    total_cnt++; if (rdy !== 1'b1) $display("FAIL oor_wr_ready got=%b exp=1", rdy); else pass_cnt++;
    test_reads("oor_addr0", 0, 8'd0, 32'hff120000);
  endtask

  task automatic test_start_and_abort();
    init_start = 1'b1; init_mode = 1'b0; init_value = 32'h12345678;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'd3;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'd4;
    #1;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL start_no_grant got=%b exp=00", {req0_ready, req1_ready}); else pass_cnt++;
    step();
    init_start = 1'b0;
    total_cnt++; if (init_busy !== 1'b1) $display("FAIL start_busy got=%b exp=1", init_busy); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL start_no_rsp got=%b exp=0", rsp_valid); else pass_cnt++;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL init_no_grant got=%b exp=00", {req0_ready, req1_ready}); else pass_cnt++;
    repeat (49) step();
    rst = 1'b1;
    #1;
    total_cnt++; if (init_busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", init_busy); else pass_cnt++;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL abort_ready got=%b exp=00", {req0_ready, req1_ready}); else pass_cnt++;
    step();
    rst = 1'b0;
    repeat (3) step();
    total_cnt++; if (init_done !== 1'b0 || init_busy !== 1'b0) $display("FAIL abort_idle got done=%b busy=%b exp 0 0", init_done, init_busy); else pass_cnt++;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL abort_uninit_ready got=%b exp=00", {req0_ready, req1_ready}); else pass_cnt++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fill(1'b0, 32'hff223344, "fill_const");
    test_reads("const_addr0", 0, 8'd0, 32'hff223344);
    test_reads("const_addr199", 1, 8'd199, 32'hff223344);
    test_fill(1'b1, 32'h0000ff12, "fill_pattern");
    test_reads("pat_addr0", 0, 8'd0, 32'hff120000);
    test_reads("pat_addr1", 1, 8'd1, 32'hff120001);
    test_reads("pat_addr2", 1, 8'd2, 32'hff120002);
    test_round_robin();
    test_write_then_read();
    test_out_of_range();
    test_start_and_abort();
    test_fill(1'b1, 32'h00000abc, "fill_restart");
    test_reads("restart_addr199", 0, 8'd199, 32'h0abc00c7);
    test_reads("restart_addr10", 1, 8'd10, 32'h0abc000a);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
